sram_1rw1r_port_ctrl: RTL
=========================

// Module: sram_1rw1r_port_ctrl
// PURPOSE
//   Front-end controller for one sky130 1rw1r OpenRAM macro (8x1024 class).
//   Shares the RW port (port 0) between a write client and a read client (rd0) with round-robin arbitration.
//   Gives a second read client (rd1) the R port (port 1).
//   Registers all macro inputs, returns read data with fixed latency, and resolves same-cycle write/read address collisions.
//   Sits between fabric clients and the macro; the macro's clk0 and clk1 are both tied to clk.
// PARAMETERS
//   ADDR_WIDTH  10  word address width
//   DATA_WIDTH  8   data word width
//   NUM_WMASKS  2   macro write-mask width; always driven all-ones
// PORTS
//   clk          in   1           single clock; also drives macro clk0 and clk1
//   rst_n        in   1           asynchronous, active-low reset
//   wr_valid     in   1           write request
//   wr_ready     out  1           write accepted this cycle
//   wr_addr      in   ADDR_WIDTH  write address
//   wr_data      in   DATA_WIDTH  write data
//   rd0_valid    in   1           port-0 read request
//   rd0_ready    out  1           rd0 accepted this cycle
//   rd0_addr     in   ADDR_WIDTH  rd0 address
//   rd0_rvalid   out  1           rd0 response valid (single-cycle pulse per read)
//   rd0_rdata    out  DATA_WIDTH  rd0 response data
//   rd1_valid    in   1           port-1 read request
//   rd1_ready    out  1           rd1 accepted this cycle
//   rd1_addr     in   ADDR_WIDTH  rd1 address
//   rd1_rvalid   out  1           rd1 response valid
//   rd1_rdata    out  DATA_WIDTH  rd1 response data
//   sram_csb0    out  1           macro csb0, active low, registered
//   sram_web0    out  1           macro web0, 0 = write, registered
//   sram_wmask0  out  NUM_WMASKS  macro wmask0, registered
//   sram_addr0   out  ADDR_WIDTH  macro addr0, registered
//   sram_din0    out  DATA_WIDTH  macro din0, registered
//   sram_dout0   in   DATA_WIDTH  macro dout0
//   sram_csb1    out  1           macro csb1, active low, registered
//   sram_addr1   out  ADDR_WIDTH  macro addr1, registered
//   sram_dout1   in   DATA_WIDTH  macro dout1
// BEHAVIOUR
//   - Reset: every register clears asynchronously on rst_n low.
//     Values: csb0 = 1, csb1 = 1, web0 = 1, wmask0 = 0, addr and din = 0, rvalids = 0, rdata = 0, rr_ptr = WR.
//     All in-flight operations are dropped; no response is ever issued for them.
//   - Handshake: a request transfers when valid && ready are high at posedge clk.
//     valid and its payload must stay stable until accepted.
//     Ready is combinational from the valids and arbitration state.
//     Responses have no backpressure.
//   - Port-0 arbitration:
//     - Only one client valid: that client gets ready.
//     - Both valid: the client named by rr_ptr gets ready.
//     - After any grant, rr_ptr points to the other client.
//   - Issue pipeline, for a request accepted at edge T:
//     - Edge T: the macro inputs are loaded (csb = 0, web0, addr, din, wmask0 = all-ones).
//     - Edge T+1: the macro samples them; it writes or reads on the following negedge.
//     - Edge T+2: rvalid goes high for one cycle and rdata is registered from sram_dout.
//     Read latency is 2 cycles, with a throughput of 1 request per cycle per port.
//     Idle cycles load csb = 1.
//   - rd0 and rd1 responses are independent and may be valid in the same cycle.
//   - Collision: wr and rd1 are both accepted-eligible in the same cycle with wr_addr == rd1_addr.
//     The write always proceeds; rd1 is handled per CONFIGURATION.
//     A read issued 1+ cycles after a write to the same address returns the new data; no extra hazard logic.
//   - Address wrap: none. Addresses are used verbatim; the full range 0..2^ADDR_WIDTH-1 is legal.
// CONFIGURATION
//   SRAM_CTRL_FWD_EN
//   - Defined: on a collision, rd1 is accepted and sram_csb1 stays 1 (no macro access).
//     At T+2, rd1_rvalid = 1 and rd1_rdata = the colliding wr_data.
//   - Undefined: on a collision, rd1_ready = 0 for that cycle.
//     rd1 is accepted on a later non-colliding cycle and reads the written data from the macro.
// TESTING
//   1. rst_n low mid-run -> csb0 = csb1 = 1, web0 = 1, both rvalid = 0 while low and on the first cycles after release.
//   2. Write 0x3FF <= 0xA5, then rd0 of 0x3FF -> rd0_rvalid exactly 2 cycles after rd0 accept, rd0_rdata = 0xA5.
//   3. wr_valid and rd0_valid held for 4 cycles from reset -> grants W, R, W, R; web0 toggles 0, 1, 0, 1 on the macro.
//   4. wr 0x010 <= 0x5A with rd1 0x010 in the same cycle:
//      - Without FWD: rd1_ready = 0 for 1 cycle, then accepted; rd1_rdata = 0x5A.
//      - With FWD: accepted immediately, csb1 stays 1, rd1_rdata = 0x5A at T+2.
//   5. rd1 reads of addresses 0..7, back to back, after preloading data = addr ^ 0xC3 -> rd1_rvalid high for 8 consecutive cycles with matching data.
//   6. rd0 accepted, then rst_n pulsed low before T+2 -> no rd0_rvalid is ever seen for that read; rr_ptr = WR after release.

Source files
------------

// File: rtl/sram_1rw1r_port_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_1rw1r_port_ctrl: controller for a sky130 1rw1r macro. Round-robin     |
// | wr/rd0 on port 0, rd1 on port 1; optional SRAM_CTRL_FWD_EN forwarding.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sram_1rw1r_port_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WMASKS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd0_valid,
  output logic                  rd0_ready,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  output logic                  rd0_rvalid,
  output logic [DATA_WIDTH-1:0] rd0_rdata,
  input  logic                  rd1_valid,
  output logic                  rd1_ready,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd1_rvalid,
  output logic [DATA_WIDTH-1:0] rd1_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam logic RR_WR  = 1'b0;
  localparam logic RR_RD0 = 1'b1;

  logic                  rr_ptr_q, rr_ptr_d;
  logic                  csb0_q, csb0_d, web0_q, web0_d;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic                  csb1_q, csb1_d;
  logic                  rd0_s1_q, rd0_s2_q, rd0_rvalid_q;
  logic                  rd1_s1_q, rd1_s2_q, rd1_rvalid_q;
  logic [DATA_WIDTH-1:0] rd0_rdata_q, rd1_rdata_q;

  logic wr_gnt, rd0_gnt, rd1_gnt, rd1_mac, collide;

  assign wr_gnt  = wr_valid  && (!rd0_valid || (rr_ptr_q == RR_WR));
  assign rd0_gnt = rd0_valid && (!wr_valid  || (rr_ptr_q == RR_RD0));
  assign collide = wr_gnt && rd1_valid && (wr_addr == rd1_addr);

`ifdef SRAM_CTRL_FWD_EN
  // A colliding rd1 is served from the write payload and never touches the macro.
  logic                  fwd_s1_q, fwd_s2_q;
  logic [DATA_WIDTH-1:0] fwd_d1_q, fwd_d2_q;
  assign rd1_gnt = rd1_valid;
  assign rd1_mac = rd1_valid && !collide;
`else
  assign rd1_gnt = rd1_valid && !collide;
  assign rd1_mac = rd1_gnt;
`endif

  assign wr_ready  = wr_gnt;
  assign rd0_ready = rd0_gnt;
  assign rd1_ready = rd1_gnt;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (wr_gnt)       rr_ptr_d = RR_RD0;
    else if (rd0_gnt) rr_ptr_d = RR_WR;
    csb0_d   = !(wr_gnt || rd0_gnt);
    web0_d   = !wr_gnt;
    wmask0_d = '1;
    addr0_d  = addr0_q;
    if (wr_gnt)       addr0_d = wr_addr;
    else if (rd0_gnt) addr0_d = rd0_addr;
    din0_d   = wr_gnt ? wr_data : din0_q;
    csb1_d   = !rd1_mac;
    addr1_d  = rd1_mac ? rd1_addr : addr1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= RR_WR;
      csb0_q       <= 1'b1;
      web0_q       <= 1'b1;
      wmask0_q     <= '0;
      addr0_q      <= '0;
      din0_q       <= '0;
      csb1_q       <= 1'b1;
      addr1_q      <= '0;
      rd0_s1_q     <= 1'b0;
      rd0_s2_q     <= 1'b0;
      rd0_rvalid_q <= 1'b0;
      rd0_rdata_q  <= '0;
      rd1_s1_q     <= 1'b0;
      rd1_s2_q     <= 1'b0;
      rd1_rvalid_q <= 1'b0;
      rd1_rdata_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      csb0_q       <= csb0_d;
      web0_q       <= web0_d;
      wmask0_q     <= wmask0_d;
      addr0_q      <= addr0_d;
      din0_q       <= din0_d;
      csb1_q       <= csb1_d;
      addr1_q      <= addr1_d;
      // Two stages cover the macro's sample edge and its negedge access.
      rd0_s1_q     <= rd0_gnt;
      rd0_s2_q     <= rd0_s1_q;
      rd0_rvalid_q <= rd0_s2_q;
      if (rd0_s2_q) rd0_rdata_q <= sram_dout0;
      rd1_s1_q     <= rd1_gnt;
      rd1_s2_q     <= rd1_s1_q;
      rd1_rvalid_q <= rd1_s2_q;
`ifdef SRAM_CTRL_FWD_EN
      if (rd1_s2_q) rd1_rdata_q <= fwd_s2_q ? fwd_d2_q : sram_dout1;
`else
      if (rd1_s2_q) rd1_rdata_q <= sram_dout1;
`endif
    end
  end

`ifdef SRAM_CTRL_FWD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_s1_q <= 1'b0;
      fwd_s2_q <= 1'b0;
      fwd_d1_q <= '0;
      fwd_d2_q <= '0;
    end else begin
      fwd_s1_q <= collide;
      fwd_s2_q <= fwd_s1_q;
      if (collide) fwd_d1_q <= wr_data;
      fwd_d2_q <= fwd_d1_q;
    end
  end
`endif

  assign sram_csb0   = csb0_q;
  assign sram_web0   = web0_q;
  assign sram_wmask0 = wmask0_q;
  assign sram_addr0  = addr0_q;
  assign sram_din0   = din0_q;
  assign sram_csb1   = csb1_q;
  assign sram_addr1  = addr1_q;
  assign rd0_rvalid  = rd0_rvalid_q;
  assign rd0_rdata   = rd0_rdata_q;
  assign rd1_rvalid  = rd1_rvalid_q;
  assign rd1_rdata   = rd1_rdata_q;

endmodule
`default_nettype wire
